// File: rtl/wb_timer.sv
// -----------------------------------------------------------------------------
// wb_timer -- machine timer (mtime / mtimecmp) behind a pipelined Wishbone B4
// slave, producing the level-sensitive machine timer interrupt for a core.
//
// A programmable 8-bit prescaler divides the clock. Each prescaler tick
// advances the 64-bit mtime counter. irq_timer_o is a registered
// unsigned compare mtime >= mtimecmp.
//
// Register map (word index = wb_adr_i[4:2], all other address bits ignored):
//   0 MTIME_LO     mtime[31:0]
//   1 MTIME_HI     mtime[63:32]
//   2 MTIMECMP_LO  mtimecmp[31:0]
//   3 MTIMECMP_HI  mtimecmp[63:32]
//   4 CTRL         bit0 EN, bits[15:8] PRESCALE, other bits read 0
//   5-7            unmapped: reads return 0, writes are discarded, both acked
//
// Ports:
//   clk          system clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   wb_cyc_i     Wishbone cycle
//   wb_stb_i     Wishbone strobe
//   wb_we_i      Wishbone write enable
//   wb_adr_i     Wishbone byte address [31:0]
//   wb_sel_i     Wishbone byte lane selects [3:0]
//   wb_dat_i     Wishbone write data [31:0]
//   wb_dat_o     Wishbone read data [31:0], registered, valid in the ack cycle
//   wb_ack_o     Wishbone acknowledge, one cycle after each accepted request
//   wb_err_o     Wishbone error, tied to 0
//   wb_stall_o   Wishbone stall, tied to 0 (a request is taken every cycle)
//   irq_timer_o  machine timer interrupt, level, active-high
// -----------------------------------------------------------------------------
module wb_timer #(
  parameter logic [7:0]  PRESCALE_RST = 8'd0,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_stall_o,
  output logic        irq_timer_o
);

  localparam logic [2:0] REG_MTIME_LO    = 3'd0;
  localparam logic [2:0] REG_MTIME_HI    = 3'd1;
  localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] REG_CTRL        = 3'd4;

  // Replace the byte lanes of old_val selected by sel with those of new_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        res[b*8 +: 8] = new_val[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // State registers
  logic [63:0] mtime_q,    mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q,       en_d;
  logic [7:0]  prescale_q, prescale_d;
  logic [7:0]  presc_q,    presc_d;
  logic        ack_q,      ack_d;
  logic [31:0] dat_q,      dat_d;
  logic        irq_q,      irq_d;

  // Bus decode
  logic        accept;
  logic        wr;
  logic        rd;
  logic [2:0]  reg_idx;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_ctrl;
  logic        tick;
  logic [63:0] mtime_inc;
  logic [31:0] rdata;
  logic        unused_adr;

  // Only the word index selects a register; the rest of the address is
  // deliberately ignored, so the map aliases across the address space.
  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  assign accept  = wb_cyc_i & wb_stb_i;
  assign wr      = accept & wb_we_i;
  assign rd      = accept & ~wb_we_i;
  assign reg_idx = wb_adr_i[4:2];

  assign wr_mtime_lo = wr && (reg_idx == REG_MTIME_LO);
  assign wr_mtime_hi = wr && (reg_idx == REG_MTIME_HI);
  assign wr_cmp_lo   = wr && (reg_idx == REG_MTIMECMP_LO);
  assign wr_cmp_hi   = wr && (reg_idx == REG_MTIMECMP_HI);
  assign wr_ctrl     = wr && (reg_idx == REG_CTRL);

  // A tick is the cycle in which the running prescaler sits at its terminal
  // count; mtime advances on the edge closing that cycle.
  assign tick      = en_q && (presc_q == prescale_q);
  assign mtime_inc = mtime_q + 64'd1;

  // Read mux, sampled at the accept edge.
  always_comb begin
    rdata = 32'd0;
    unique case (reg_idx)
      REG_MTIME_LO:    rdata = mtime_q[31:0];
      REG_MTIME_HI:    rdata = mtime_q[63:32];
      REG_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
      REG_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
      REG_CTRL:        rdata = {16'd0, prescale_q, 7'd0, en_q};
      default:         rdata = 32'd0;
    endcase
  end

  // Control register and prescaler
  always_comb begin
    en_d       = en_q;
    prescale_d = prescale_q;
    presc_d    = presc_q;

    if (!en_q) begin
      presc_d = 8'd0;
    end else if (tick) begin
      presc_d = 8'd0;
    end else begin
      presc_d = presc_q + 8'd1;
    end

    if (wr_ctrl) begin
      if (wb_sel_i[0]) begin
        en_d = wb_dat_i[0];
      end
      // A new divide value restarts the prescaler so the first period after
      // the write is a full one at the new rate.
      if (wb_sel_i[1]) begin
        prescale_d = wb_dat_i[15:8];
        presc_d    = 8'd0;
      end
    end
  end

  // mtime: a software write to either half replaces the whole increment for
  // that cycle, so the written value is exactly what software sees next.
  always_comb begin
    mtime_d = tick ? mtime_inc : mtime_q;
    if (wr_mtime_lo) begin
      mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wb_dat_i, wb_sel_i)};
    end else if (wr_mtime_hi) begin
      mtime_d = {merge_bytes(mtime_q[63:32], wb_dat_i, wb_sel_i), mtime_q[31:0]};
    end
  end

  // mtimecmp: plain byte-writable storage, no shadowing of the halves.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr_cmp_lo) begin
      mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], wb_dat_i, wb_sel_i);
    end else if (wr_cmp_hi) begin
      mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wb_dat_i, wb_sel_i);
    end
  end

  // Bus response and interrupt
  always_comb begin
    ack_d = accept;
    dat_d = rd ? rdata : dat_q;
    irq_d = (mtime_q >= mtimecmp_q);
  end

  // Register stage: requests seen while rst is high are dropped, and any
  // pending ack is cancelled because ack_q is forced low.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= MTIMECMP_RST;
      en_q       <= 1'b0;
      prescale_q <= PRESCALE_RST;
      presc_q    <= 8'd0;
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      prescale_q <= prescale_d;
      presc_q    <= presc_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      irq_q      <= irq_d;
    end
  end

  assign wb_dat_o    = dat_q;
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = 1'b0;
  assign wb_stall_o  = 1'b0;
  assign irq_timer_o = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// -----------------------------------------------------------------------------
// tb_wb_timer -- directed self-checking bench for wb_timer.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same offset, i.e. away from the active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic [31:0] wb_adr = 32'd0;
  logic [3:0]  wb_sel = 4'd0;
  logic [31:0] wb_dat_w = 32'd0;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_stall;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_timer #(
    .PRESCALE_RST(8'd0),
    .MTIMECMP_RST(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_cyc_i   (wb_cyc),
    .wb_stb_i   (wb_stb),
    .wb_we_i    (wb_we),
    .wb_adr_i   (wb_adr),
    .wb_sel_i   (wb_sel),
    .wb_dat_i   (wb_dat_w),
    .wb_dat_o   (wb_dat_r),
    .wb_ack_o   (wb_ack),
    .wb_err_o   (wb_err),
    .wb_stall_o (wb_stall),
    .irq_timer_o(irq)
  );

  task automatic bus_idle();
    wb_cyc   = 1'b0;
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
    wb_adr   = 32'd0;
    wb_sel   = 4'd0;
    wb_dat_w = 32'd0;
  endtask

  // Present one read; returns in the ack cycle with that cycle's ack/data.
  task automatic wb_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic ack);
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wb_we  = 1'b0;
    wb_adr = addr;
    wb_sel = 4'hF;
    @(posedge clk); #1;
    ack  = wb_ack;
    data = wb_dat_r;
    bus_idle();
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, output logic ack);
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    wb_we    = 1'b1;
    wb_adr   = addr;
    wb_sel   = sel;
    wb_dat_w = data;
    @(posedge clk); #1;
    ack = wb_ack;
    bus_idle();
  endtask

  task automatic do_reset();
    bus_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        a;
    logic [31:0] exp_rd [5] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    bus_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", wb_ack); end
    checks++; if (wb_dat_r !== 32'd0) begin errors++; $display("FAIL rst_dat got %h exp 0", wb_dat_r); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    checks++; if (wb_stall !== 1'b0 || wb_err !== 1'b0) begin
      errors++; $display("FAIL rst_stall_err got %b%b exp 00", wb_stall, wb_err);
    end
    for (int i = 0; i < 5; i++) begin
      wb_read(32'(i * 4), d, a);
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL rst_read_ack%0d got %b exp 1", i, a); end
      checks++; if (d !== exp_rd[i]) begin errors++; $display("FAIL rst_read%0d got %h exp %h", i, d, exp_rd[i]); end
    end
    @(posedge clk); #1;
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL single_ack got %b exp 0", wb_ack); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq_after got %b exp 0", irq); end
  endtask

  task automatic test_count_irq();
    logic [31:0] d;
    logic        a;
    do_reset();
    wb_write(32'h0C, 32'h0, 4'hF, a);
    wb_write(32'h08, 32'd10, 4'hF, a);
    wb_write(32'h10, 32'h1, 4'hF, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL ctrl_wr_ack got %b exp 1", a); end
    // Read j returns mtime as left by the previous edge: j-1.
    for (int j = 1; j <= 12; j++) begin
      wb_read(32'h00, d, a);
      checks++; if (d !== 32'(j - 1)) begin errors++; $display("FAIL count_rd%0d got %h exp %h", j, d, 32'(j - 1)); end
      if (j == 10) begin
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
      end
      if (j >= 11) begin
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise%0d got %b exp 1", j, irq); end
      end
    end
    wb_write(32'h08, 32'd100, 4'hF, a);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b exp 1", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop got %b exp 0", irq); end
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    logic        a;
    logic [31:0] exp_a [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
    logic [31:0] exp_b [5] = '{2, 2, 3, 3, 4};
    do_reset();
    wb_write(32'h10, 32'h0000_0301, 4'hF, a);
    for (int j = 0; j < 9; j++) begin
      wb_read(32'h00, d, a);
      checks++; if (d !== exp_a[j]) begin errors++; $display("FAIL presc3_rd%0d got %h exp %h", j, d, exp_a[j]); end
    end
    wb_write(32'h10, 32'h0000_0101, 4'hF, a);
    for (int j = 0; j < 5; j++) begin
      wb_read(32'h00, d, a);
      checks++; if (d !== exp_b[j]) begin errors++; $display("FAIL presc1_rd%0d got %h exp %h", j, d, exp_b[j]); end
    end
  endtask

  task automatic test_carry_and_tick_write();
    logic [31:0] d;
    logic        a;
    do_reset();
    wb_write(32'h00, 32'hFFFF_FFFF, 4'hF, a);
    wb_write(32'h04, 32'h0, 4'hF, a);
    wb_write(32'h10, 32'h1, 4'hF, a);
    wb_read(32'h00, d, a);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL carry_lo0 got %h exp ffffffff", d); end
    wb_read(32'h04, d, a);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL carry_hi got %h exp 1", d); end
    wb_read(32'h00, d, a);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL carry_lo1 got %h exp 1", d); end
    // Every cycle ticks here; the byte write must win over the increment.
    wb_write(32'h00, 32'h1234_5655, 4'b0001, a);
    wb_read(32'h00, d, a);
    checks++; if (d !== 32'h55) begin errors++; $display("FAIL tick_wr_lo got %h exp 55", d); end
    wb_read(32'h04, d, a);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL tick_wr_hi got %h exp 1", d); end
    wb_read(32'h00, d, a);
    checks++; if (d !== 32'h57) begin errors++; $display("FAIL tick_wr_resume got %h exp 57", d); end
  endtask

  task automatic test_ctrl_enable();
    logic [31:0] d;
    logic        a;
    do_reset();
    wb_write(32'h10, 32'hFFFF_FFFE, 4'hF, a);
    wb_read(32'h10, d, a);
    checks++; if (d !== 32'h0000_FF00) begin errors++; $display("FAIL ctrl_rb got %h exp 0000ff00", d); end
    wb_write(32'h10, 32'h1, 4'hF, a);
    wb_write(32'h10, 32'h0, 4'hF, a);
    repeat (10) @(posedge clk);
    #1;
    wb_read(32'h00, d, a);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL en_hold got %h exp 1", d); end
    wb_read(32'h04, d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL en_hold_hi got %h exp 0", d); end
  endtask

  task automatic test_unmapped_and_sel();
    logic [31:0] d;
    logic        a;
    do_reset();
    wb_write(32'h14, 32'hFFFF_FFFF, 4'hF, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL unmap_wr_ack got %b exp 1", a); end
    wb_read(32'h14, d, a);
    checks++; if (a !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmap_rd got %b/%h exp 1/0", a, d); end
    wb_read(32'h00, d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmap_side got %h exp 0", d); end
    wb_write(32'h08, 32'h0000_AB00, 4'b0010, a);
    wb_read(32'h28, d, a);
    checks++; if (d !== 32'hFFFF_ABFF) begin errors++; $display("FAIL sel_alias got %h exp ffffabff", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        a;
    logic [31:0] addrs [4] = '{32'h08, 32'h0C, 32'h10, 32'h00};
    logic [31:0] exps  [4] = '{32'h0000_1234, 32'hABCD_0000, 32'h0000_0500, 32'h0};
    do_reset();
    wb_write(32'h08, 32'h0000_1234, 4'hF, a);
    wb_write(32'h0C, 32'hABCD_0000, 4'hF, a);
    wb_write(32'h10, 32'h0000_0500, 4'hF, a);
    for (int i = 0; i < 4; i++) begin
      wb_read(addrs[i], d, a);
      checks++; if (a !== 1'b1 || d !== exps[i]) begin
        errors++; $display("FAIL b2b_rd%0d got %b/%h exp 1/%h", i, a, d, exps[i]);
      end
    end
    // Back-to-back reads with reset raised during the second ack.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF; wb_adr = 32'h08;
    @(posedge clk); #1;
    checks++; if (wb_ack !== 1'b1 || wb_dat_r !== 32'h0000_1234) begin
      errors++; $display("FAIL rr_ack1 got %b/%h exp 1/00001234", wb_ack, wb_dat_r);
    end
    wb_adr = 32'h0C;
    @(posedge clk); #1;
    checks++; if (wb_ack !== 1'b1 || wb_dat_r !== 32'hABCD_0000) begin
      errors++; $display("FAIL rr_ack2 got %b/%h exp 1/abcd0000", wb_ack, wb_dat_r);
    end
    wb_adr = 32'h10;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL rr_ack3 got %b exp 0", wb_ack); end
    wb_adr = 32'h00;
    @(posedge clk); #1;
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL rr_ack4 got %b exp 0", wb_ack); end
    rst = 1'b0;
    bus_idle();
    @(posedge clk); #1;
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL rr_ack5 got %b exp 0", wb_ack); end
    wb_read(32'h08, d, a);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rr_cmp_lo got %h exp ffffffff", d); end
    wb_read(32'h0C, d, a);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rr_cmp_hi got %h exp ffffffff", d); end
    wb_read(32'h10, d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rr_ctrl got %h exp 0", d); end
    wb_read(32'h1C, d, a);
    checks++; if (a !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL rr_1c got %b/%h exp 1/0", a, d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rr_irq got %b exp 0", irq); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count_irq();
    test_prescale();
    test_carry_and_tick_write();
    test_ctrl_enable();
    test_unmapped_and_sel();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 Parameter PRESCALE_RST, default 0: reset value of the 8-bit prescaler divide field (tick every PRESCALE+1 clocks).
REQ-002 Parameter MTIMECMP_RST, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wb  wb_if slave modport  —  pipelined Wishbone B4 slave, 32-bit data, byte selects: cyc, stb, we, adr[31:0], sel[3:0], dat_i[31:0], dat_o[31:0], ack, err, stall.
REQ-006 irq_timer  output  1  machine timer interrupt to the core, level, active-high.

Function
REQ-007 Register map, decoded on adr[4:2] only; 0: MTIME_LO, 1: MTIME_HI, 2: MTIMECMP_LO, 3: MTIMECMP_HI, 4: CTRL, 5-7: unmapped.
REQ-008 CTRL: bit0 EN (counter enable), bits[15:8] PRESCALE, all other bits read 0 and ignore writes.
REQ-009 stall shall be constantly 0; a request is accepted in every cycle with cyc & stb high.
REQ-010 ack shall assert exactly one cycle after each accepted request, for one cycle per request; back-to-back requests get back-to-back acks.
REQ-011 err shall be constantly 0; unmapped reads return 0 with ack, unmapped writes are acked and discarded.
REQ-012 Read data shall be registered and valid on dat_o in the ack cycle, sampled from register values at the accept edge.
REQ-013 Writes shall honour sel per byte lane; unselected bytes unchanged; write takes effect at the accept edge.
REQ-014 Prescaler: 8-bit counter; when EN=1 it increments each clock, and on reaching PRESCALE it wraps to 0 and generates a one-cycle tick.
REQ-015 When EN=0 the prescaler holds at 0 and no ticks occur; mtime holds.
REQ-016 Each tick increments mtime as a 64-bit value; carry from LO to HI in the same cycle; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-017 Write to MTIME_LO/HI coincident with a tick: the written bytes take the write value, the tick increment is discarded for that cycle (write wins, whole 64-bit increment dropped).
REQ-018 Writing CTRL.PRESCALE resets the prescaler counter to 0.
REQ-019 irq_timer shall be registered: irq_timer <= (mtime >= mtimecmp) using the register values of the current cycle, unsigned 64-bit compare, independent of EN.
REQ-020 Consequently irq_timer reflects any mtime/mtimecmp change with exactly one cycle latency after the updating edge.
REQ-021 64-bit registers are not atomically updated; software sequencing (write MTIMECMP_HI to all ones first) is the driver's responsibility; the block performs no shadowing.

Reset
REQ-022 On rst: mtime=0, mtimecmp=MTIMECMP_RST, EN=0, PRESCALE=PRESCALE_RST, prescaler=0, ack=0, dat_o=0, irq_timer=0.
REQ-023 A request accepted in the cycle rst is high shall be dropped; no ack follows it.
REQ-024 Reset asserted while an ack is due shall cancel that ack; ack is 0 in the cycle after the reset edge.

Verification
REQ-025 After reset, read addresses 0x00..0x10 -> 0, 0, FFFFFFFF, FFFFFFFF, 0x00000000 (PRESCALE_RST=0); one ack per read, each one cycle after accept; irq_timer=0.
REQ-026 Write CTRL=0x0000_0001, MTIMECMP_HI=0, MTIMECMP_LO=10 -> mtime increments every clock; irq_timer rises exactly one cycle after the edge where mtime becomes 10, stays high; writing MTIMECMP_LO=100 drops it one cycle later.
REQ-027 Write CTRL=0x0000_0301 (PRESCALE=3) -> mtime increments once every 4 clocks; mid-run write PRESCALE=1 -> prescaler restarts, next tick 2 clocks later.
REQ-028 Write MTIME_LO=FFFF_FFFF, MTIME_HI=0, EN=1, PRESCALE=0 -> next tick yields MTIME_HI=1, MTIME_LO=0; write MTIME_LO with sel=4'b0001 of 0x55 on a tick cycle -> only byte0 changes to 0x55, no increment that cycle.
REQ-029 Four back-to-back accepted reads with stall=0 -> four consecutive ack cycles with correct data; assert rst during the second ack -> no further acks, all registers at reset values, read of 0x1C afterwards -> 0 with ack.
